// File: rtl/mem_bist_master.sv
// Memory BIST initiator: fills a wrapping address range with a pattern over a valid/ready port,
// reads it back, compares each word and reports pass/fail, error count and first failing address.
module mem_bist_master #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned ADDR  = 8,
    parameter int unsigned TMO   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDR-1:0]  start_addr,
    input  logic [ADDR:0]    num_loc,
    input  logic [1:0]       pattern,
    input  logic [WIDTH-1:0] seed,
    output logic [ADDR-1:0]  addr,
    output logic [WIDTH-1:0] wdata,
    output logic             wrbar,
    output logic             valid,
    input  logic [WIDTH-1:0] rdata,
    input  logic             ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [ADDR:0]    err_cnt,
    output logic [ADDR-1:0]  first_err_addr
);

    localparam int unsigned CW = ADDR + 1;
    localparam int unsigned TW = $clog2(TMO + 1);

    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

    state_t           state;
    logic [ADDR-1:0]  base;
    logic [CW-1:0]    count;
    logic [CW-1:0]    idx;
    logic [1:0]       pat;
    logic [WIDTH-1:0] seed_q;
    logic [TW-1:0]    wcnt;

    logic [CW-1:0]    num_clamp_c;
    logic             last_c;
    logic             miss_c;
    logic [ADDR-1:0]  addr_next_c;

    // Data word expected at address a for pattern p
    function automatic logic [WIDTH-1:0] pat_fn(input logic [ADDR-1:0] a, input logic [1:0] p,
                                                input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        r = WIDTH'(a);
        case (p)
            2'd0: r = WIDTH'(a);
            2'd1: r = ~WIDTH'(a);
            2'd2: for (int i = 0; i < int'(WIDTH); i++) r[i] = 1'(i % 2) ^ a[0];
            default: r = s;
        endcase
        return r;
    endfunction

    assign num_clamp_c = (num_loc > CW'(DEPTH)) ? CW'(DEPTH) : num_loc;
    assign last_c      = (idx == CW'(count - 1'b1));
    assign miss_c      = (rdata != pat_fn(addr, pat, seed_q));
    assign addr_next_c = ADDR'(addr + 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            addr           <= '0;
            wdata          <= '0;
            wrbar          <= 1'b0;
            valid          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            base           <= '0;
            count          <= '0;
            idx            <= '0;
            pat            <= '0;
            seed_q         <= '0;
            wcnt           <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base           <= start_addr;
                        count          <= num_clamp_c;
                        pat            <= pattern;
                        seed_q         <= seed;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        pass           <= 1'b0;
                        timeout        <= 1'b0;
                        idx            <= '0;
                        wcnt           <= '0;
                        if (num_clamp_c == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= WR;
                        end
                    end
                end
                WR, RD: begin
                    if (!valid) begin
                        // Present the first beat of a phase
                        valid <= 1'b1;
                        addr  <= base;
                        wrbar <= (state == WR);
                        wdata <= (state == WR) ? pat_fn(base, pat, seed_q) : '0;
                        wcnt  <= '0;
                    end else if (ready) begin
                        wcnt <= '0;
                        if (state == RD && miss_c) begin
                            if (err_cnt != '1) err_cnt <= CW'(err_cnt + 1'b1);
                            if (err_cnt == '0) first_err_addr <= addr;
                        end
                        if (last_c) begin
                            idx   <= '0;
                            valid <= 1'b0;
                            wrbar <= 1'b0;
                            wdata <= '0;
                            if (state == WR) begin
                                state <= RD;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                addr  <= '0;
                                pass  <= (err_cnt == '0) && !miss_c;
                            end
                        end else begin
                            idx   <= CW'(idx + 1'b1);
                            addr  <= addr_next_c;
                            wdata <= (state == WR) ? pat_fn(addr_next_c, pat, seed_q) : '0;
                        end
                    end else if (wcnt == TW'(TMO - 1)) begin
                        // Ready never came for this beat: abort the run
                        timeout <= 1'b1;
                        valid   <= 1'b0;
                        wrbar   <= 1'b0;
                        addr    <= '0;
                        wdata   <= '0;
                        busy    <= 1'b0;
                        pass    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wcnt <= TW'(wcnt + 1'b1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist_master.sv
// Bench for mem_bist_master: behavioural memory with ready shaping and fault injection,
// an expected-beat queue built from the pattern rules, and per-run result checks.
module tb_mem_bist_master;

    localparam int W = 32;
    localparam int D = 256;
    localparam int A = 8;
    localparam int T = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [A-1:0]  start_addr = '0;
    logic [A:0]    num_loc = '0;
    logic [1:0]    pattern = '0;
    logic [W-1:0]  seed = '0;
    logic [A-1:0]  addr;
    logic [W-1:0]  wdata;
    logic          wrbar;
    logic          valid;
    logic [W-1:0]  rdata;
    logic          ready = 1'b0;
    logic          busy;
    logic          done;
    logic          pass;
    logic          timeout;
    logic [A:0]    err_cnt;
    logic [A-1:0]  first_err_addr;

    mem_bist_master #(.WIDTH(W), .DEPTH(D), .ADDR(A), .TMO(T)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .num_loc(num_loc),
        .pattern(pattern), .seed(seed), .addr(addr), .wdata(wdata), .wrbar(wrbar),
        .valid(valid), .rdata(rdata), .ready(ready), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .err_cnt(err_cnt), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         wr;
        logic [A-1:0] a;
        logic [W-1:0] d;
    } beat_t;

    beat_t        exp_q[$];
    logic [W-1:0] mem [D];
    logic         fault_en = 1'b0;
    logic [A-1:0] fault_addr = '0;
    int           rmode = 0;
    int           cyc = 0;
    int           writes_done = 0;
    int           done_seen = 0;
    int           stall_cycles = 0;
    int           beats = 0;
    logic         held_v = 1'b0;
    beat_t        held;
    int           n_pass = 0;
    int           n_total = 0;

    assign rdata = mem[addr] ^ ((fault_en && addr == fault_addr) ? 32'h1 : 32'h0);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] model_pat(input logic [A-1:0] a, input logic [1:0] p,
                                               input logic [W-1:0] s);
        case (p)
            2'd0: return {24'h0, a};
            2'd1: return ~{24'h0, a};
            2'd2: return a[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
            default: return s;
        endcase
    endfunction

    // Memory model and per-cycle protocol compare, away from the active edge
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        logic  r;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            cur = '{wr: wrbar, a: addr, d: wdata};
            if (valid) check("busy_with_valid", 64'(busy), 64'd1);
            if (held_v && valid) check("hold_stable", 64'(cur), 64'(held));
            if (done) begin
                done_seen++;
                check("busy_at_done", 64'(busy), 64'd0);
            end
            case (rmode)
                1: r = (cyc % 3 == 0);
                2: r = (writes_done < 4);
                default: r = 1'b1;
            endcase
            ready = r;
            if (valid && !r) stall_cycles++;
            if (valid && r) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'(cur), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(cur), 64'(e));
                end
                if (wrbar) begin
                    mem[addr] = wdata;
                    writes_done++;
                end
            end
            held_v = valid && !r;
            held   = cur;
            cyc++;
        end
    end

    task automatic run(input logic [A-1:0] sa, input logic [A:0] n, input logic [1:0] p,
                       input logic [W-1:0] sd, input bit wait_done, output int lat);
        int neff;
        @(negedge clk);
        exp_q.delete();
        neff = (n > 9'(D)) ? D : int'(n);
        for (int i = 0; i < neff; i++) exp_q.push_back('{1'b1, A'(sa + A'(i)), model_pat(A'(sa + A'(i)), p, sd)});
        for (int i = 0; i < neff; i++) exp_q.push_back('{1'b0, A'(sa + A'(i)), 32'h0});
        done_seen = 0; stall_cycles = 0; beats = 0; writes_done = 0;
        start_addr = sa; num_loc = n; pattern = p; seed = sd; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        if (wait_done) begin
            for (int k = 1; k <= 5000; k++) begin
                @(negedge clk);
                if (done) begin
                    lat = k - 1;
                    break;
                end
            end
            if (lat < 0) check("done_wait_expired", 64'd0, 64'd1);
        end
    endtask

    task automatic results(input string tag, input logic ep, input logic eto, input int ecnt,
                           input int efirst);
        check({tag, "_pass"}, 64'(pass), 64'(ep));
        check({tag, "_timeout"}, 64'(timeout), 64'(eto));
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'(ecnt));
        check({tag, "_first_err"}, 64'(first_err_addr), 64'(efirst));
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, 64'(done_seen), 64'd1);
        check({tag, "_pass_hold"}, 64'(pass), 64'(ep));
        check({tag, "_valid_idle"}, 64'(valid), 64'd0);
    endtask

    initial begin
        int lat;
        bit in_rd;
        #1 rst = 1'b1;
        #3;
        check("rst_outputs", 64'({addr, wdata, wrbar, valid, busy, done, pass, timeout}), 64'd0);
        check("rst_err", 64'({err_cnt, first_err_addr}), 64'd0);
        #20 rst = 1'b0;

        // Fill/readback, address pattern, always ready
        run(8'd0, 9'd32, 2'd0, 32'h0, 1'b1, lat);
        check("t1_latency", 64'(lat), 64'd66);
        check("t1_word31", 64'(mem[31]), 64'd31);
        check("t1_word5", 64'(mem[5]), 64'd5);
        check("t1_leftover", 64'(exp_q.size()), 64'd0);
        results("t1", 1'b1, 1'b0, 0, 0);

        // Zero-length run finishes at once
        run(8'd7, 9'd0, 2'd0, 32'h0, 1'b1, lat);
        check("t0_latency", 64'(lat), 64'd0);
        check("t0_beats", 64'(beats), 64'd0);
        results("t0", 1'b1, 1'b0, 0, 0);

        // Wrap-around with inverted address
        run(8'd250, 9'd10, 2'd1, 32'h0, 1'b1, lat);
        check("t2_word0", 64'(mem[0]), 64'hFFFF_FFFF);
        check("t2_word255", 64'(mem[255]), 64'hFFFF_FF00);
        check("t2_leftover", 64'(exp_q.size()), 64'd0);
        results("t2", 1'b1, 1'b0, 0, 0);

        // Injected single-bit read fault at word 17, seed pattern
        fault_en = 1'b1; fault_addr = 8'd17;
        run(8'd0, 9'd32, 2'd3, 32'h1234_5678, 1'b1, lat);
        check("t3_word17", 64'(mem[17]), 64'h1234_5678);
        results("t3", 1'b0, 1'b0, 1, 17);
        fault_en = 1'b0;

        // Stalling ready, full depth, checkerboard
        rmode = 1;
        run(8'd0, 9'd256, 2'd2, 32'h0, 1'b1, lat);
        check("t4_beats", 64'(beats), 64'd512);
        check("t4_stalled", 64'(stall_cycles > 0), 64'd1);
        check("t4_word1", 64'(mem[1]), 64'h5555_5555);
        results("t4", 1'b1, 1'b0, 0, 0);
        run(8'd3, 9'd300, 2'd0, 32'h0, 1'b1, lat);
        check("t4_clamp_beats", 64'(beats), 64'd512);
        check("t4_clamp_leftover", 64'(exp_q.size()), 64'd0);
        results("t4c", 1'b1, 1'b0, 0, 0);

        // Ready stuck low from the fifth write
        rmode = 2;
        run(8'd0, 9'd32, 2'd0, 32'h0, 1'b1, lat);
        check("t5_stall_cycles", 64'(stall_cycles), 64'(T));
        check("t5_writes", 64'(writes_done), 64'd4);
        results("t5", 1'b0, 1'b1, 0, 0);

        // Reset during the read phase, then a clean run
        rmode = 0;
        run(8'd0, 9'd32, 2'd0, 32'h0, 1'b0, lat);
        in_rd = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (valid && !wrbar) begin
                in_rd = 1'b1;
                break;
            end
        end
        check("t6_reached_rd", 64'(in_rd), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_valid_rst", 64'(valid), 64'd0);
        check("t6_busy_rst", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run(8'd100, 9'd20, 2'd2, 32'h0, 1'b1, lat);
        check("t6_leftover", 64'(exp_q.size()), 64'd0);
        results("t6", 1'b1, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
